// File: rtl/xs3_serializer.sv
// Excess-3 serializer: one-hot BCD digit in, framed serial excess-3 code out.
// Optional odd-parity fifth bit when XS3_SER_PARITY_EN is defined.
module xs3_serializer #(
    parameter int LSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           dec_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 frame_start,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef XS3_SER_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif
    localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 1);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [3:0]             gapcnt_q, gapcnt_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [3:0]             ones;
    logic [3:0]             digit;
    logic                   onehot;
    logic [3:0]             code;
    logic [FRAME_LEN-1:0]   frame_word;
    logic                   last_bit;
    logic                   accept;

    // Popcount and index of the highest set line; index is only used when one-hot.
    always_comb begin
        ones  = '0;
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (dec_in[i]) begin
                ones  = ones + 4'd1;
                digit = 4'(i);
            end
        end
        onehot = (ones == 4'd1);
        code   = digit + 4'd3;
    end

    // Frame is pre-ordered so the shifter always emits bit 0 first.
    always_comb begin
        frame_word = '0;
        for (int i = 0; i < 4; i++) begin
            frame_word[i] = (LSB_FIRST != 0) ? code[i] : code[3-i];
        end
`ifdef XS3_SER_PARITY_EN
        frame_word[4] = ~^code;
`endif
    end

    assign last_bit = (state_q == SHIFT) && (bitcnt_q == LAST_BIT);
    assign in_ready = !rst && ((state_q == IDLE) || (last_bit && (GAP_CYCLES == 0)));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        gapcnt_d  = gapcnt_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (accept && !onehot) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept && onehot) begin
                    state_d  = SHIFT;
                    shreg_d  = frame_word;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;
                end else if (accept && onehot) begin
                    shreg_d  = frame_word;
                    bitcnt_d = '0;
                end else begin
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    if (!accept && (GAP_CYCLES > 0)) begin
                        state_d  = GAP;
                        gapcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gapcnt_q == GAP_LAST) begin
                    state_d  = IDLE;
                    gapcnt_d = '0;
                end else begin
                    gapcnt_d = gapcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            gapcnt_q  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            gapcnt_q  <= gapcnt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ser_valid   = (state_q == SHIFT);
    assign ser_out     = ser_valid && shreg_q[0];
    assign frame_start = ser_valid && (bitcnt_q == '0);
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_xs3_serializer.sv
// Bench for xs3_serializer: unit 0 is LSB-first with no gap, unit 1 MSB-first with a 2-cycle gap.
module tb_xs3_serializer;

`ifdef XS3_SER_PARITY_EN
    localparam int F = 5;
`else
    localparam int F = 4;
`endif
    localparam int GAP1 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] dec_in      [2];
    logic       in_valid    [2];
    logic       in_ready    [2];
    logic       ser_out     [2];
    logic       ser_valid   [2];
    logic       frame_start [2];
    logic       err         [2];
    logic [7:0] err_cnt     [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xs3_serializer #(.LSB_FIRST(1), .GAP_CYCLES(0), .ERR_CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .dec_in(dec_in[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .frame_start(frame_start[0]), .err(err[0]), .err_cnt(err_cnt[0]));

    xs3_serializer #(.LSB_FIRST(0), .GAP_CYCLES(GAP1), .ERR_CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .dec_in(dec_in[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .frame_start(frame_start[1]), .err(err[1]), .err_cnt(err_cnt[1]));

    typedef struct {
        logic [9:0] dec;
        logic       valid;
        logic [3:0] code;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gap_of(input int u);
        return (u == 0) ? 0 : GAP1;
    endfunction

    // Transmit-order bits of a frame: index 0 goes out first.
    function automatic logic [4:0] frame_bits(input int u, input logic [3:0] code);
        logic [4:0] b;
        int ones;
        b = '0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            b[i] = (u == 0) ? code[i] : code[3-i];
            ones += int'(code[i]);
        end
        b[4] = ((ones % 2) == 0);
        return b;
    endfunction

    function automatic int popcnt(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int digit_of(input logic [9:0] v);
        int d;
        d = 0;
        for (int i = 0; i < 10; i++) if (v[i]) d = i;
        return d;
    endfunction

    task automatic wait_ready(input int u, input string name);
        int k;
        k = 0;
        while (!in_ready[u] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(k < 50), 1);
    endtask

    task automatic send_collect(input int u, input logic [9:0] d, output int bits,
                                output int nbits, output int fs_mask, output int nerr,
                                output int zv);
        @(negedge clk);
        in_valid[u] = 1'b1;
        dec_in[u]   = d;
        wait_ready(u, "handshake");
        @(negedge clk);
        in_valid[u] = 1'b0;
        bits = 0; nbits = 0; fs_mask = 0; nerr = 0; zv = 0;
        for (int c = 0; c < F + 4; c++) begin
            if (ser_valid[u]) begin
                bits = bits | (int'(ser_out[u]) << nbits);
                if (frame_start[u]) fs_mask = fs_mask | (1 << nbits);
                nbits++;
            end else if (ser_out[u] || frame_start[u]) begin
                zv++;
            end
            if (err[u]) nerr++;
            @(negedge clk);
        end
    endtask

    // Two frames offered back to back; second word is held until accepted.
    task automatic stream2(input int u, input logic [3:0] c1, input logic [3:0] c2,
                           input logic [9:0] d1, input logic [9:0] d2);
        int ev, eo, ef, av, ao, af, off, s, rdy_last;
        logic drop;
        logic [4:0] b1, b2;
        s = 2 * F + gap_of(u) + 4;
        off = (gap_of(u) == 0) ? F : F + gap_of(u) + 1;
        b1 = frame_bits(u, c1);
        b2 = frame_bits(u, c2);
        ev = 0; eo = 0; ef = (1 << 0) | (1 << off);
        for (int i = 0; i < F; i++) begin
            ev |= (1 << i) | (1 << (off + i));
            eo |= (int'(b1[i]) << i) | (int'(b2[i]) << (off + i));
        end
        @(negedge clk);
        in_valid[u] = 1'b1;
        dec_in[u]   = d1;
        wait_ready(u, "b2b_handshake");
        @(negedge clk);
        dec_in[u] = d2;
        av = 0; ao = 0; af = 0; rdy_last = 0; drop = 1'b0;
        for (int i = 0; i < s; i++) begin
            av |= int'(ser_valid[u]) << i;
            ao |= int'(ser_out[u]) << i;
            af |= int'(frame_start[u]) << i;
            if (i == F - 1) rdy_last = int'(in_ready[u]);
            if (drop) in_valid[u] = 1'b0;
            else if (in_valid[u] && in_ready[u]) drop = 1'b1;
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
        check($sformatf("b2b_u%0d_valid", u), av, ev);
        check($sformatf("b2b_u%0d_data", u), ao, eo);
        check($sformatf("b2b_u%0d_fstart", u), af, ef);
        check($sformatf("b2b_u%0d_ready_lastbit", u), rdy_last, int'(gap_of(u) == 0));
    endtask

    // Random traffic checked against a frame-level queue model.
    task automatic rand_run(input int u, input int ncyc);
        logic exp_q[$];
        logic obs_q[$];
        logic [4:0] eb;
        int exp_err, obs_err, exp_fr, obs_fs, zv, base, mism, sat;
        logic acc;
        exp_err = 0; obs_err = 0; exp_fr = 0; obs_fs = 0; zv = 0; mism = 0;
        base = int'(err_cnt[u]);
        acc = 1'b0;
        @(negedge clk);
        for (int c = 0; c < ncyc + F + gap_of(u) + 4; c++) begin
            if (ser_valid[u]) begin
                obs_q.push_back(ser_out[u]);
                if (frame_start[u]) obs_fs++;
            end else if (ser_out[u]) begin
                zv++;
            end
            if (err[u]) obs_err++;
            if (c < ncyc) begin
                if (!in_valid[u] || acc) begin
                    if ($urandom_range(0, 99) < 60) begin
                        in_valid[u] = 1'b1;
                        if ($urandom_range(0, 9) < 8) dec_in[u] = 10'(1) << $urandom_range(0, 9);
                        else dec_in[u] = 10'($urandom);
                    end else begin
                        in_valid[u] = 1'b0;
                    end
                end
            end else begin
                in_valid[u] = 1'b0;
            end
            acc = in_valid[u] && in_ready[u];
            if (acc) begin
                if (popcnt(dec_in[u]) == 1) begin
                    eb = frame_bits(u, 4'(digit_of(dec_in[u]) + 3));
                    for (int i = 0; i < F; i++) exp_q.push_back(eb[i]);
                    exp_fr++;
                end else begin
                    exp_err++;
                end
            end
            @(negedge clk);
        end
        check($sformatf("rand_u%0d_nbits", u), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) mism++;
        check($sformatf("rand_u%0d_bit_mismatches", u), mism, 0);
        check($sformatf("rand_u%0d_frames", u), obs_fs, exp_fr);
        check($sformatf("rand_u%0d_err_pulses", u), obs_err, exp_err);
        check($sformatf("rand_u%0d_idle_zero", u), zv, 0);
        sat = (base + exp_err > 255) ? 255 : base + exp_err;
        check($sformatf("rand_u%0d_err_cnt", u), int'(err_cnt[u]), sat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        int bits, nbits, fsm, nerr, zv, expb;
        logic [4:0] eb;

        tbl[0]  = '{10'b0000000000, 1'b0, 4'd0};
        tbl[1]  = '{10'b0000000011, 1'b0, 4'd0};
        tbl[2]  = '{10'b0000000001, 1'b1, 4'b0011};
        tbl[3]  = '{10'b0000000010, 1'b1, 4'b0100};
        tbl[4]  = '{10'b0000000100, 1'b1, 4'b0101};
        tbl[5]  = '{10'b0000001000, 1'b1, 4'b0110};
        tbl[6]  = '{10'b0000010000, 1'b1, 4'b0111};
        tbl[7]  = '{10'b0000100000, 1'b1, 4'b1000};
        tbl[8]  = '{10'b0001000000, 1'b1, 4'b1001};
        tbl[9]  = '{10'b0010000000, 1'b1, 4'b1010};
        tbl[10] = '{10'b0100000000, 1'b1, 4'b1011};
        tbl[11] = '{10'b1000000000, 1'b1, 4'b1100};
        tbl[12] = '{10'b1111111111, 1'b0, 4'd0};

        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0;
            dec_in[u]   = '0;
        end

        // Reset state
        #12;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_u%0d_in_ready", u), int'(in_ready[u]), 0);
            check($sformatf("rst_u%0d_outputs", u),
                  int'(ser_out[u]) + int'(ser_valid[u]) + int'(frame_start[u]) + int'(err[u]), 0);
            check($sformatf("rst_u%0d_err_cnt", u), int'(err_cnt[u]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready[0]), 1);

        // Table-driven single words on both units
        for (int u = 0; u < 2; u++) begin
            for (int e = 0; e < 13; e++) begin
                send_collect(u, tbl[e].dec, bits, nbits, fsm, nerr, zv);
                eb = frame_bits(u, tbl[e].code);
                expb = tbl[e].valid ? (int'(eb) & ((1 << F) - 1)) : 0;
                check($sformatf("tbl%0d_u%0d_nbits", e, u), nbits, tbl[e].valid ? F : 0);
                check($sformatf("tbl%0d_u%0d_bits", e, u), bits, expb);
                check($sformatf("tbl%0d_u%0d_fstart", e, u), fsm, int'(tbl[e].valid));
                check($sformatf("tbl%0d_u%0d_err", e, u), nerr, int'(!tbl[e].valid));
                check($sformatf("tbl%0d_u%0d_idle_zero", e, u), zv, 0);
                if (e == 1) check($sformatf("u%0d_err_cnt_after_two", u), int'(err_cnt[u]), 2);
            end
            check($sformatf("u%0d_err_cnt_after_table", u), int'(err_cnt[u]), 3);
        end

        // Back-to-back: digit 5 then digit 7
        stream2(0, 4'd8, 4'd10, 10'b0000100000, 10'b0010000000);
        stream2(1, 4'd8, 4'd10, 10'b0000100000, 10'b0010000000);

        // Invalid word during the last bit drops to idle without a frame
        begin
            int nv, ne;
            @(negedge clk);
            in_valid[0] = 1'b1;
            dec_in[0]   = 10'b0000010000;
            wait_ready(0, "inv_last_handshake");
            @(negedge clk);
            dec_in[0] = 10'b0000110000;
            nv = 0; ne = 0;
            for (int i = 0; i < 2 * F + 3; i++) begin
                nv += int'(ser_valid[0]);
                ne += int'(err[0]);
                if (i == F - 1) begin
                    @(negedge clk);
                    in_valid[0] = 1'b0;
                    nv += int'(ser_valid[0]);
                    ne += int'(err[0]);
                    check("inv_last_idle_ready", int'(in_ready[0]), 1);
                end
                @(negedge clk);
            end
            check("inv_last_valid_cycles", nv, F);
            check("inv_last_err_pulses", ne, 1);
        end

        rand_run(0, 600);
        rand_run(1, 600);

        // Saturation: invalid words every cycle from idle
        @(negedge clk);
        in_valid[0] = 1'b1;
        dec_in[0]   = 10'b0000000000;
        repeat (260) @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("err_cnt_saturate", int'(err_cnt[0]), 255);

        // Reset during bit 2 of digit 4
        begin
            int nv;
            @(negedge clk);
            in_valid[0] = 1'b1;
            dec_in[0]   = 10'b0000010000;
            wait_ready(0, "rst_mid_handshake");
            @(negedge clk);
            in_valid[0] = 1'b0;
            repeat (2) @(negedge clk);
            check("rst_mid_was_shifting", int'(ser_valid[0]), 1);
            #1 rst = 1'b1;
            #1;
            check("rst_mid_outputs", int'(ser_out[0]) + int'(ser_valid[0]) +
                  int'(frame_start[0]) + int'(err[0]), 0);
            check("rst_mid_err_cnt", int'(err_cnt[0]), 0);
            check("rst_mid_in_ready", int'(in_ready[0]), 0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("rst_rel_in_ready", int'(in_ready[0]), 1);
            nv = 0;
            for (int i = 0; i < F + 2; i++) begin
                @(negedge clk);
                nv += int'(ser_valid[0]);
            end
            check("rst_rel_no_bits", nv, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xs3_serializer.md
Name: xs3_serializer

Overview:
- Downstream stage of the 4-to-10 BCD digit decoder.
- Consumes the decoder's 10-bit one-hot digit lines and encodes the digit to a 4-bit excess-3 code (digit+3).
- Shifts the code out serially with a valid/ready input handshake and a framed serial output.
- Rejects non-one-hot inputs (all-zero, or two or more lines high) and counts them.

Parameters:
- LSB_FIRST, 1, 1 = shift bit0 first; 0 = shift bit3 first.
- GAP_CYCLES, 0, number of idle cycles forced between frames (0..15).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- dec_in  input  10  one-hot digit lines; bit d high means digit d.
- in_valid  input  1  dec_in is valid this cycle.
- in_ready  output  1  block can accept dec_in this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit.
- frame_start  output  1  high on the first bit of each frame.
- err  output  1  one-cycle pulse when an accepted dec_in is not one-hot.
- err_cnt  output  ERR_CNT_W  saturating count of rejected inputs.

Behaviour:
- Reset (async, while rst=1):
  - State goes to IDLE.
  - ser_out=0, ser_valid=0, frame_start=0, err=0, err_cnt=0, shift register and bit counter=0.
  - in_ready is forced to 0 while rst is high.
- States: IDLE, SHIFT, GAP.
- Accept: a transfer occurs on any edge where in_valid && in_ready. dec_in is sampled on that edge only.
- in_ready is combinational from state:
  - 1 in IDLE.
  - 1 in the last SHIFT bit cycle only when GAP_CYCLES==0, allowing back-to-back frames.
  - 0 otherwise.
- Valid accept (exactly one bit set, index d):
  - Load code = d+3 (4 bits; digit 0 gives 0011, digit 9 gives 1100).
  - Go to SHIFT with bit counter 0.
  - Latency: the first bit appears on ser_out/ser_valid in the cycle after the accepting edge.
- SHIFT:
  - ser_valid=1 for exactly FRAME_LEN consecutive cycles (4, or 5 with parity).
  - Bit order is set by LSB_FIRST.
  - frame_start=1 on bit 0 only.
- End of the last bit:
  - If a valid accept happens on that edge, reload and stay in SHIFT (no bubble).
  - Else, if GAP_CYCLES>0, go to GAP.
  - Else go to IDLE.
- GAP: ser_valid=0 for GAP_CYCLES cycles, then IDLE.
- Invalid accept (popcount(dec_in) != 1):
  - err=1 for the following cycle; no frame is produced.
  - err_cnt increments, saturating at all-ones.
  - Next state is IDLE, including when the invalid word is accepted during the last SHIFT bit.
- in_valid without in_ready: ignored, no err. The upstream stage must hold its data.
- ser_out is 0 whenever ser_valid=0.
- Reset mid-frame: the frame is abandoned immediately; no partial bits after rst deasserts.

Optional Feature:
- Macro: XS3_SER_PARITY_EN.
- Defined:
  - A 5th bit is appended after the 4 code bits: odd parity over the code, so the total number of ones in the 5 bits is odd.
  - FRAME_LEN=5. The back-to-back in_ready window moves to bit 4.
- Undefined: FRAME_LEN=4; no parity logic is present.

Test Plan:
- Reset then dec_in=10'b0000000001, in_valid=1 for 1 cycle, LSB_FIRST=1 -> ser_valid for 4 cycles, ser_out 1,1,0,0 (0011); frame_start on the first bit only; err=0.
- dec_in=10'b1000000000 (digit 9), LSB_FIRST=0 -> ser_out 1,1,0,0 (code 1100, MSB first).
- GAP_CYCLES=0; digit 5 then digit 7 held valid, with the second accepted in the last bit cycle -> 8 contiguous ser_valid cycles, LSB-first 0,0,0,1 (1000) then 0,1,0,1 (1010); frame_start at cycles 1 and 5.
- dec_in=10'b0000000000, then dec_in=10'b0000000011 -> two err pulses, no ser_valid, err_cnt=2. Forcing 256 invalid words with ERR_CNT_W=8 -> err_cnt holds at 255.
- rst asserted during bit 2 of digit 4 -> all outputs 0 at once; after release, in_ready=1 and no remaining bits are emitted.
- XS3_SER_PARITY_EN defined, digit 0 (0011) -> 5 bits 1,1,0,0,1. Digit 1 (0100) -> 0,0,1,0,0.
